// File: rtl/memory_io.sv
`default_nettype none
// ============================================================================
// Module   : memory_io
// Brief    : CPU data-memory map with 16K RAM, 8K screen shadow feeding a
//            4-entry display FIFO, and a single-word keyboard register.
// Revision : 1.0 - initial release
// ============================================================================
module memory_io (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        kbd_ready,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  localparam logic [14:0] c_KBD_ADDR = 15'h6000;
  localparam logic [2:0]  c_FIFO_FULL = 3'd4;

  // Storage
  logic [15:0] r_ram    [0:16383];
  logic [15:0] r_shadow [0:8191];
  logic [12:0] r_fifo_addr [0:3];
  logic [15:0] r_fifo_data [0:3];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic        r_overflow;
  logic [15:0] r_kr;

  // Decode and strobes
  logic [14:0] w_a;
  logic        w_unused;
  logic        w_sel_ram;
  logic        w_sel_scr;
  logic        w_sel_kbd;
  logic        w_wr_ram;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_store;
  logic        w_kbd_clear;
  logic        w_kbd_load;

  // Bit 15 of the address is not part of the decoded map.
  assign w_a       = addressM[14:0];
  assign w_unused  = addressM[15];

  assign w_sel_ram = ~w_a[14];
  assign w_sel_scr = (w_a[14:13] == 2'b10);
  assign w_sel_kbd = (w_a == c_KBD_ADDR);

  // Reset masks every write-side effect, including memory updates.
  assign w_wr_ram    = writeM & w_sel_ram & ~reset;
  assign w_push      = writeM & w_sel_scr & ~reset;
  assign w_pop       = (r_count != 3'd0) & scr_ready;
  assign w_full      = (r_count == c_FIFO_FULL);
  // A push at full only lands when the head leaves on the same edge.
  assign w_store     = w_push & (~w_full | w_pop);
  assign w_kbd_clear = writeM & w_sel_kbd;
  assign w_kbd_load  = kbd_valid & kbd_ready;

  assign kbd_ready    = (r_kr == 16'h0000);
  assign scr_valid    = (r_count != 3'd0);
  assign scr_addr     = r_fifo_addr[r_rptr];
  assign scr_data     = r_fifo_data[r_rptr];
  assign scr_overflow = r_overflow;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[w_a[13:0]] <= outM;
    end
  end

  // Screen shadow write port; updated even when the FIFO drops the entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_shadow[w_a[12:0]] <= outM;
    end
  end

  // FIFO entry storage, written at the write pointer.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_fifo_addr[r_wptr] <= w_a[12:0];
      r_fifo_data[r_wptr] <= outM;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push & ~w_store) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Keyboard register: CPU acknowledge beats a new key on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kr <= 16'h0000;
    end else if (w_kbd_clear) begin
      r_kr <= 16'h0000;
    end else if (w_kbd_load) begin
      r_kr <= kbd_code;
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    inM = 16'h0000;
    if (w_sel_ram) begin
      inM = r_ram[w_a[13:0]];
    end else if (w_sel_scr) begin
      inM = r_shadow[w_a[12:0]];
    end else if (w_sel_kbd) begin
      inM = r_kr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_io
// Brief    : Self-checking bench for memory_io with directed scenarios and a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_io;

  logic        clk;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        scr_overflow;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [15:0] m_ram    [int];
  logic [15:0] m_shadow [int];
  logic [12:0] m_qa [$];
  logic [15:0] m_qd [$];
  logic [15:0] m_kr;
  logic        m_ovf;

  memory_io dut (
    .clk          (clk),
    .reset        (reset),
    .addressM     (addressM),
    .outM         (outM),
    .writeM       (writeM),
    .inM          (inM),
    .kbd_valid    (kbd_valid),
    .kbd_code     (kbd_code),
    .kbd_ready    (kbd_ready),
    .scr_valid    (scr_valid),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .scr_ready    (scr_ready),
    .scr_overflow (scr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the memory-map rules to the model for the coming edge.
  task automatic model_edge();
    int  a;
    bit  pop;
    bit  push;
    a = int'(addressM[14:0]);
    if (reset) begin
      m_qa.delete();
      m_qd.delete();
      m_kr  = 16'h0000;
      m_ovf = 1'b0;
      return;
    end
    pop  = (m_qa.size() != 0) && scr_ready;
    push = writeM && (a >= 'h4000) && (a < 'h6000);
    if (pop) begin
      void'(m_qa.pop_front());
      void'(m_qd.pop_front());
    end
    if (push) begin
      m_shadow[a - 'h4000] = outM;
      if (m_qa.size() < 4) begin
        m_qa.push_back(13'(a - 'h4000));
        m_qd.push_back(outM);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (writeM && a < 'h4000) m_ram[a] = outM;
    if (writeM && a == 'h6000) m_kr = 16'h0000;
    else if (kbd_valid && m_kr == 16'h0000) m_kr = kbd_code;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeM    = 1'b0;
    kbd_valid = 1'b0;
    scr_ready = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; writeM = 1'b0; kbd_valid = 1'b0; scr_ready = 1'b0;
    addressM = 16'h0000; outM = 16'h0000; kbd_code = 16'h0001;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (scr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_scr_valid got %b want 0", scr_valid); end
    n_checks++;
    if (kbd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_kbd_ready got %b want 1", kbd_ready); end
    n_checks++;
    if (scr_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", scr_overflow); end
  endtask

  task automatic test_ram_unmapped();
    idle();
    addressM = 16'h0005; outM = 16'h1234; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h1234) begin n_errors++; $display("FAIL ram_readback got %h want 1234", inM); end
    addressM = 16'h8005; #1;
    n_checks++;
    if (inM !== 16'h1234) begin n_errors++; $display("FAIL ram_bit15_ignored got %h want 1234", inM); end
    addressM = 16'h7000; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_errors++; $display("FAIL unmapped_read got %h want 0000", inM); end
    outM = 16'hFFFF; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0000) begin n_errors++; $display("FAIL unmapped_after_write got %h want 0000", inM); end
    addressM = 16'h0005; #1;
    n_checks++;
    if (inM !== 16'h1234 || scr_valid !== 1'b0 || kbd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL unmapped_no_effect got inM=%h v=%b kr=%b want 1234 0 1", inM, scr_valid, kbd_ready);
    end
  endtask

  task automatic test_screen_overflow();
    idle();
    for (int i = 0; i < 5; i++) begin
      addressM = 16'h4000 + 16'(i); outM = 16'(i + 1); writeM = 1'b1;
      tick();
    end
    writeM = 1'b0; addressM = 16'h4004; #1;
    n_checks++;
    if (scr_valid !== 1'b1 || scr_addr !== 13'h0000 || scr_data !== 16'h0001) begin
      n_errors++;
      $display("FAIL ovf_head got v=%b a=%h d=%h want 1 0000 0001", scr_valid, scr_addr, scr_data);
    end
    n_checks++;
    if (scr_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b want 1", scr_overflow); end
    n_checks++;
    if (inM !== 16'h0005) begin n_errors++; $display("FAIL ovf_shadow got %h want 0005", inM); end
    tick();
    n_checks++;
    if (scr_data !== 16'h0001 || scr_addr !== 13'h0000) begin
      n_errors++;
      $display("FAIL hold_stable got a=%h d=%h want 0000 0001", scr_addr, scr_data);
    end
  endtask

  task automatic test_drain();
    idle();
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (scr_valid !== 1'b1 || scr_addr !== 13'(i) || scr_data !== 16'(i + 1)) begin
        n_errors++;
        $display("FAIL drain_head%0d got v=%b a=%h d=%h want 1 %h %h", i, scr_valid, scr_addr, scr_data, i, i + 1);
      end
      tick();
    end
    n_checks++;
    if (scr_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got %b want 0", scr_valid); end
    scr_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    idle();
    for (int i = 0; i < 4; i++) begin
      addressM = 16'h4010 + 16'(i); outM = 16'h0010 + 16'(i); writeM = 1'b1;
      tick();
    end
    addressM = 16'h4020; outM = 16'hAAAA; writeM = 1'b1; scr_ready = 1'b1;
    tick();
    writeM = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_checks++;
      if (scr_data !== 16'h0010 + 16'(i)) begin
        n_errors++;
        $display("FAIL pp_full_head%0d got %h want %h", i, scr_data, 16'h0010 + 16'(i));
      end
      tick();
    end
    n_checks++;
    if (scr_valid !== 1'b1 || scr_addr !== 13'h0020 || scr_data !== 16'hAAAA) begin
      n_errors++;
      $display("FAIL pp_full_new got v=%b a=%h d=%h want 1 0020 aaaa", scr_valid, scr_addr, scr_data);
    end
    tick();
    n_checks++;
    if (scr_valid !== 1'b0) begin n_errors++; $display("FAIL pp_full_empty got %b want 0", scr_valid); end
    scr_ready = 1'b0;
  endtask

  task automatic test_kbd();
    idle();
    addressM = 16'h6000; kbd_valid = 1'b1; kbd_code = 16'h0041;
    tick();
    n_checks++;
    if (inM !== 16'h0041 || kbd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL kbd_load got inM=%h rdy=%b want 0041 0", inM, kbd_ready);
    end
    kbd_code = 16'h0042;
    tick();
    n_checks++;
    if (inM !== 16'h0041) begin n_errors++; $display("FAIL kbd_hold got %h want 0041", inM); end
    writeM = 1'b1; outM = 16'hFFFF;
    tick();
    writeM = 1'b0; #1;
    n_checks++;
    if (inM !== 16'h0000 || kbd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL kbd_clear_prio got inM=%h rdy=%b want 0000 1", inM, kbd_ready);
    end
    tick();
    n_checks++;
    if (inM !== 16'h0042) begin n_errors++; $display("FAIL kbd_reload got %h want 0042", inM); end
    kbd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle();
    addressM = 16'h6000; writeM = 1'b1;
    tick();
    writeM = 1'b0; kbd_valid = 1'b1; kbd_code = 16'h0041;
    tick();
    kbd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addressM = 16'h4100 + 16'(i); outM = 16'h0100 + 16'(i); writeM = 1'b1;
      tick();
    end
    writeM = 1'b0; scr_ready = 1'b1;
    tick();
    scr_ready = 1'b0;
    // Reset edge with competing write, pop, key load and RAM write.
    reset = 1'b1; scr_ready = 1'b1; kbd_valid = 1'b1; kbd_code = 16'h0055;
    writeM = 1'b1; addressM = 16'h0005; outM = 16'hDEAD;
    tick();
    idle();
    #1;
    n_checks++;
    if (scr_valid !== 1'b0 || kbd_ready !== 1'b1 || scr_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid got v=%b rdy=%b ovf=%b want 0 1 0", scr_valid, kbd_ready, scr_overflow);
    end
    n_checks++;
    if (inM !== 16'h1234) begin n_errors++; $display("FAIL reset_ram_kept got %h want 1234", inM); end
    addressM = 16'h4104; #1;
    n_checks++;
    if (inM !== 16'h0104) begin n_errors++; $display("FAIL reset_shadow_kept got %h want 0104", inM); end
  endtask

  task automatic test_random();
    logic [15:0] exp_in;
    bit          known;
    int          a;
    int          sel;
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: addressM = 16'($urandom_range(0, 15));
        4, 5, 6:    addressM = 16'h4000 + 16'($urandom_range(0, 15));
        7:          addressM = 16'h6000;
        8:          addressM = 16'h6001 + 16'($urandom_range(0, 'h1FFE));
        default:    addressM = 16'h3FF0 + 16'($urandom_range(0, 15));
      endcase
      addressM[15] = 1'($urandom_range(0, 1));
      outM      = 16'($urandom);
      writeM    = ($urandom_range(0, 1) == 1);
      scr_ready = ($urandom_range(0, 2) == 0);
      kbd_valid = ($urandom_range(0, 2) == 0);
      kbd_code  = 16'($urandom_range(1, 'hFFFF));
      reset     = ($urandom_range(0, 59) == 0);
      #1;
      a = int'(addressM[14:0]);
      known  = 1'b1;
      exp_in = 16'h0000;
      if (a < 'h4000) begin
        known = m_ram.exists(a);
        if (known) exp_in = m_ram[a];
      end else if (a < 'h6000) begin
        known = m_shadow.exists(a - 'h4000);
        if (known) exp_in = m_shadow[a - 'h4000];
      end else if (a == 'h6000) begin
        exp_in = m_kr;
      end
      if (known) begin
        n_checks++;
        if (inM !== exp_in) begin
          n_errors++;
          $display("FAIL rand_inM n=%0d addr=%h got %h want %h", n, addressM, inM, exp_in);
        end
      end
      tick();
      n_checks++;
      if (scr_valid !== (m_qa.size() != 0) || kbd_ready !== (m_kr == 16'h0000) || scr_overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rand_flags n=%0d got v=%b rdy=%b ovf=%b want %b %b %b", n, scr_valid, kbd_ready,
                 scr_overflow, m_qa.size() != 0, m_kr == 16'h0000, m_ovf);
      end
      if (m_qa.size() != 0) begin
        n_checks++;
        if (scr_addr !== m_qa[0] || scr_data !== m_qd[0]) begin
          n_errors++;
          $display("FAIL rand_head n=%0d got a=%h d=%h want %h %h", n, scr_addr, scr_data, m_qa[0], m_qd[0]);
        end
      end
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_kr  = 16'h0000;
    m_ovf = 1'b0;
    test_reset();
    test_ram_unmapped();
    test_screen_overflow();
    test_drain();
    test_push_pop_full();
    test_kbd();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_io.md
MEMORY_IO -- requirements
Module: memory_io

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port addressM, input, 16 bits: data address from CPU; only bits [14:0] are decoded, bit 15 is ignored.
REQ-004 SHALL have port outM, input, 16 bits: write data from CPU.
REQ-005 SHALL have port writeM, input, 1 bit: write strobe from CPU, active-high.
REQ-006 SHALL have port inM, output, 16 bits: read data to CPU, combinational from addressM[14:0].
REQ-007 SHALL have port kbd_valid, input, 1 bit: keyboard source offers kbd_code.
REQ-008 SHALL have port kbd_code, input, 16 bits: key code; a value of 0 is never offered.
REQ-009 SHALL have port kbd_ready, output, 1 bit: keyboard register can accept a code.
REQ-010 SHALL have port scr_valid, output, 1 bit: display FIFO head is valid.
REQ-011 SHALL have port scr_addr, output, 13 bits: screen word index of the FIFO head.
REQ-012 SHALL have port scr_data, output, 16 bits: pixel word of the FIFO head.
REQ-013 SHALL have port scr_ready, input, 1 bit: display accepts the FIFO head.
REQ-014 SHALL have port scr_overflow, output, 1 bit: sticky flag, set when a screen write is dropped.

Function
REQ-015 SHALL decode A=addressM[14:0] as follows: RAM for 0x0000-0x3FFF (16K x 16); SCREEN for 0x4000-0x5FFF (8K x 16 shadow); KBD at 0x6000; UNMAPPED for 0x6001-0x7FFF.
REQ-016 SHALL drive inM combinationally in the same cycle: RAM[A], SCREEN[A-0x4000], the keyboard register, or 0x0000 for UNMAPPED.
REQ-017 SHALL perform writes at the rising clock edge when writeM=1; a read of the same address in the following cycle returns the new value.
REQ-018 SHALL ignore writes to UNMAPPED addresses, with no state change.
REQ-019 SHALL, on a SCREEN write, update the shadow word and push {A-0x4000, outM} into a 4-entry FIFO.
REQ-020 SHALL implement the FIFO with 2-bit read and write pointers that wrap from 3 to 0, plus a 3-bit count ranging 0-4.
REQ-021 SHALL drive scr_valid = (count != 0), with scr_addr/scr_data taken from the head entry; a pushed entry is first visible one cycle after the write edge.
REQ-022 SHALL pop the FIFO on an edge where scr_valid=1 and scr_ready=1; scr_addr/scr_data SHALL hold stable while scr_valid=1 and scr_ready=0.
REQ-023 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; this SHALL also apply when count=4.
REQ-024 SHALL, on a push at count=4 without a pop, drop the entry: the shadow is still updated, scr_overflow is set to 1, and pointers and count are unchanged.
REQ-025 SHALL hold the keyboard register (KR) as 16 bits; kbd_ready = (KR == 0).
REQ-026 SHALL load KR with kbd_code on an edge where kbd_valid=1 and kbd_ready=1.
REQ-027 SHALL, on a CPU write to KBD, clear KR to 0 regardless of the outM value; this acknowledges the key.
REQ-028 SHALL give the CPU clear priority when a clear and a kbd load fall on the same edge: KR becomes 0 and the offered code is not accepted (kbd_ready was 0).
REQ-029 SHALL contain no other state; RAM and SCREEN contents are not initialised.

Reset
REQ-030 SHALL, when reset=1 at an edge: clear KR to 0 (kbd_ready=1); empty the FIFO (pointers=0, count=0, scr_valid=0); clear scr_overflow to 0.
REQ-031 SHALL leave RAM and SHADOW contents unchanged by reset.
REQ-032 SHALL ignore writeM, kbd_valid and scr_ready on a reset edge; reset wins over any simultaneous push, pop or load.
REQ-033 SHALL discard pending FIFO entries when reset is asserted mid-operation.

Verification
REQ-034 SHALL be verified by: write 0x1234 to A=0x0005, then read A=0x0005 the next cycle -> inM=0x1234; read A=0x7000 -> inM=0x0000; a write to 0x7000 changes no state.
REQ-035 SHALL be verified by: scr_ready=0 and 5 writes to A=0x4000..0x4004 with data 1..5 -> scr_valid=1, head={0x0000,1}, scr_overflow=1; read A=0x4004 -> inM=5.
REQ-036 SHALL be verified by: continuing REQ-035 with scr_ready=1 -> heads 1,2,3,4 in consecutive cycles, then scr_valid=0; entry 5 is never emitted.
REQ-037 SHALL be verified by: at count=4, a push and pop on the same edge -> count stays 4 and the new entry appears after 3 further pops.
REQ-038 SHALL be verified by: kbd_valid=1, code=0x0041 -> inM at 0x6000 reads 0x0041 and kbd_ready=0; a second code 0x0042 is not accepted; a CPU write to 0x6000 -> KR=0, then 0x0042 loads on the next edge.
REQ-039 SHALL be verified by: reset with 3 FIFO entries, KR=0x0041 and overflow=1 -> next cycle scr_valid=0, kbd_ready=1, scr_overflow=0, and RAM[5] still reads 0x1234.
